// File: rtl/control_unit_if.sv
// Control bundle between the sequencer and the accumulator datapath: opcode and
// flags flow into the controller, load strobes and mux/ALU selects flow out.
interface control_unit_if;
    logic [7:0] IR;
    logic [3:0] CCR_Result;
    logic       IR_Load;
    logic       MAR_Load;
    logic       PC_Load;
    logic       PC_Inc;
    logic       A_Load;
    logic       B_Load;
    logic [2:0] ALU_Sel;
    logic       CCR_Load;
    logic [1:0] Bus1_Sel;
    logic [1:0] Bus2_Sel;
    logic       write;

    modport master (
        input  IR, CCR_Result,
        output IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load,
               ALU_Sel, CCR_Load, Bus1_Sel, Bus2_Sel, write
    );

    modport slave (
        output IR, CCR_Result,
        input  IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load,
               ALU_Sel, CCR_Load, Bus1_Sel, Bus2_Sel, write
    );
endinterface

// File: rtl/control_unit.sv
// Moore fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Define COND_BRANCH_EXT_EN to add the BMI/BNE/BCS conditional branches.
module control_unit #(
    parameter int         Z_BIT   = 2,
    parameter logic [2:0] ALU_ADD = 3'b000,
    parameter logic [2:0] ALU_SUB = 3'b001
) (
    input  logic                Clk,
    input  logic                Reset,
    control_unit_if.master      cu,
    output logic [5:0]          dbg_state_o
);

    typedef enum logic [5:0] {
        S_FETCH_0, S_FETCH_1, S_FETCH_2, S_DECODE_3,
        S_LDA_IMM_4, S_LDA_IMM_5, S_LDA_IMM_6,
        S_LDA_DIR_4, S_LDA_DIR_5, S_LDA_DIR_6, S_LDA_DIR_7, S_LDA_DIR_8,
        S_LDB_IMM_4, S_LDB_IMM_5, S_LDB_IMM_6,
        S_LDB_DIR_4, S_LDB_DIR_5, S_LDB_DIR_6, S_LDB_DIR_7, S_LDB_DIR_8,
        S_STA_DIR_4, S_STA_DIR_5, S_STA_DIR_6, S_STA_DIR_7,
        S_STB_DIR_4, S_STB_DIR_5, S_STB_DIR_6, S_STB_DIR_7,
        S_ADD_AB_4, S_SUB_AB_4,
        S_BRA_4, S_BRA_5, S_BRA_6,
        S_BR_SKIP_4
    } state_e;

    typedef struct packed {
        logic       ir_load;
        logic       mar_load;
        logic       pc_load;
        logic       pc_inc;
        logic       a_load;
        logic       b_load;
        logic [2:0] alu_sel;
        logic       ccr_load;
        logic [1:0] bus1_sel;
        logic [1:0] bus2_sel;
        logic       write;
    } ctrl_t;

`ifdef COND_BRANCH_EXT_EN
    localparam int N_BIT = 3;
    localparam int C_BIT = 0;
`endif

    state_e state_q, state_d;
    ctrl_t  ctrl_q, ctrl_o;

    // Output decode for a given state; registered against the next state so the
    // strobes line up with the state that owns them.
    function automatic ctrl_t state_outputs(input state_e s);
        ctrl_t o;
        o = '0;
        case (s)
            S_FETCH_0: begin
                o.bus2_sel = 2'b01;
                o.mar_load = 1'b1;
            end
            S_FETCH_1, S_LDA_IMM_5, S_LDA_DIR_5, S_LDB_IMM_5, S_LDB_DIR_5,
            S_STA_DIR_5, S_STB_DIR_5, S_BR_SKIP_4: begin
                o.pc_inc = 1'b1;
            end
            S_FETCH_2: begin
                o.bus2_sel = 2'b10;
                o.ir_load  = 1'b1;
            end
            S_LDA_IMM_4, S_LDA_DIR_4, S_LDB_IMM_4, S_LDB_DIR_4,
            S_STA_DIR_4, S_STB_DIR_4, S_BRA_4: begin
                o.bus2_sel = 2'b01;
                o.mar_load = 1'b1;
            end
            S_LDA_DIR_6, S_LDB_DIR_6, S_STA_DIR_6, S_STB_DIR_6: begin
                o.bus2_sel = 2'b10;
                o.mar_load = 1'b1;
            end
            S_LDA_IMM_6, S_LDA_DIR_8: begin
                o.bus2_sel = 2'b10;
                o.a_load   = 1'b1;
            end
            S_LDB_IMM_6, S_LDB_DIR_8: begin
                o.bus2_sel = 2'b10;
                o.b_load   = 1'b1;
            end
            S_STA_DIR_7: begin
                o.bus1_sel = 2'b01;
                o.write    = 1'b1;
            end
            S_STB_DIR_7: begin
                o.bus1_sel = 2'b10;
                o.write    = 1'b1;
            end
            S_ADD_AB_4, S_SUB_AB_4: begin
                o.bus1_sel = 2'b10;
                o.alu_sel  = (s == S_ADD_AB_4) ? ALU_ADD : ALU_SUB;
                o.a_load   = 1'b1;
                o.ccr_load = 1'b1;
            end
            S_BRA_6: begin
                o.bus2_sel = 2'b10;
                o.pc_load  = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    always_comb begin
        state_d = S_FETCH_0;
        case (state_q)
            S_FETCH_0:   state_d = S_FETCH_1;
            S_FETCH_1:   state_d = S_FETCH_2;
            S_FETCH_2:   state_d = S_DECODE_3;
            S_DECODE_3: begin
                case (cu.IR)
                    8'h86: state_d = S_LDA_IMM_4;
                    8'h87: state_d = S_LDA_DIR_4;
                    8'h88: state_d = S_LDB_IMM_4;
                    8'h89: state_d = S_LDB_DIR_4;
                    8'h96: state_d = S_STA_DIR_4;
                    8'h97: state_d = S_STB_DIR_4;
                    8'h42: state_d = S_ADD_AB_4;
                    8'h43: state_d = S_SUB_AB_4;
                    8'h20: state_d = S_BRA_4;
                    8'h23: state_d = cu.CCR_Result[Z_BIT] ? S_BRA_4 : S_BR_SKIP_4;
`ifdef COND_BRANCH_EXT_EN
                    8'h21: state_d = cu.CCR_Result[N_BIT] ? S_BRA_4 : S_BR_SKIP_4;
                    8'h22: state_d = cu.CCR_Result[Z_BIT] ? S_BR_SKIP_4 : S_BRA_4;
                    8'h25: state_d = cu.CCR_Result[C_BIT] ? S_BRA_4 : S_BR_SKIP_4;
`else
                    8'h21, 8'h22, 8'h25: state_d = S_FETCH_0;
`endif
                    default: state_d = S_FETCH_0;
                endcase
            end
            S_LDA_IMM_4: state_d = S_LDA_IMM_5;
            S_LDA_IMM_5: state_d = S_LDA_IMM_6;
            S_LDA_DIR_4: state_d = S_LDA_DIR_5;
            S_LDA_DIR_5: state_d = S_LDA_DIR_6;
            S_LDA_DIR_6: state_d = S_LDA_DIR_7;
            S_LDA_DIR_7: state_d = S_LDA_DIR_8;
            S_LDB_IMM_4: state_d = S_LDB_IMM_5;
            S_LDB_IMM_5: state_d = S_LDB_IMM_6;
            S_LDB_DIR_4: state_d = S_LDB_DIR_5;
            S_LDB_DIR_5: state_d = S_LDB_DIR_6;
            S_LDB_DIR_6: state_d = S_LDB_DIR_7;
            S_LDB_DIR_7: state_d = S_LDB_DIR_8;
            S_STA_DIR_4: state_d = S_STA_DIR_5;
            S_STA_DIR_5: state_d = S_STA_DIR_6;
            S_STA_DIR_6: state_d = S_STA_DIR_7;
            S_STB_DIR_4: state_d = S_STB_DIR_5;
            S_STB_DIR_5: state_d = S_STB_DIR_6;
            S_STB_DIR_6: state_d = S_STB_DIR_7;
            S_BRA_4:     state_d = S_BRA_5;
            S_BRA_5:     state_d = S_BRA_6;
            default:     state_d = S_FETCH_0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_FETCH_0;
            ctrl_q  <= state_outputs(S_FETCH_0);
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_outputs(state_d);
        end
    end

    // Reset masks the registered strobes so the datapath sees idle immediately.
    assign ctrl_o = Reset ? '0 : ctrl_q;

    assign cu.IR_Load  = ctrl_o.ir_load;
    assign cu.MAR_Load = ctrl_o.mar_load;
    assign cu.PC_Load  = ctrl_o.pc_load;
    assign cu.PC_Inc   = ctrl_o.pc_inc;
    assign cu.A_Load   = ctrl_o.a_load;
    assign cu.B_Load   = ctrl_o.b_load;
    assign cu.ALU_Sel  = ctrl_o.alu_sel;
    assign cu.CCR_Load = ctrl_o.ccr_load;
    assign cu.Bus1_Sel = ctrl_o.bus1_sel;
    assign cu.Bus2_Sel = ctrl_o.bus2_sel;
    assign cu.write    = ctrl_o.write;

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a per-instruction strobe-trace model feeds an expected
// queue that a negedge monitor drains, one entry per clock cycle.
module tb_control_unit;
  localparam int W = 15;
  localparam logic [7:0] S_IR  = 8'h80;
  localparam logic [7:0] S_MAR = 8'h40;
  localparam logic [7:0] S_PCL = 8'h20;
  localparam logic [7:0] S_PCI = 8'h10;
  localparam logic [7:0] S_A   = 8'h08;
  localparam logic [7:0] S_B   = 8'h04;
  localparam logic [7:0] S_CCR = 8'h02;
  localparam logic [7:0] S_WR  = 8'h01;

  logic       Clk;
  logic       Reset;
  logic [5:0] dbg_state;
  logic       run;
  int         tests;
  int         fails;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] trace_q[$];
  logic [W-1:0] act;

  control_unit_if cu ();

  control_unit dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .cu          (cu.master),
    .dbg_state_o (dbg_state)
  );

  assign act = {cu.IR_Load, cu.MAR_Load, cu.PC_Load, cu.PC_Inc, cu.A_Load,
                cu.B_Load, cu.CCR_Load, cu.write, cu.ALU_Sel, cu.Bus1_Sel,
                cu.Bus2_Sel};

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] mk(input logic [7:0] strb, input logic [1:0] b1,
                                      input logic [1:0] b2, input logic [2:0] alu);
    return {strb, alu, b1, b2};
  endfunction

  // reference model: the cycle-by-cycle strobe pattern of one instruction
  task automatic build_trace(input logic [7:0] op, input logic [3:0] ccr);
    logic [W-1:0] opaddr;
    logic taken;
    logic is_branch;
    opaddr = mk(S_MAR, 2'b00, 2'b01, 3'b000);
    trace_q.delete();
    trace_q.push_back(mk(S_MAR, 2'b00, 2'b01, 3'b000));
    trace_q.push_back(mk(S_PCI, 2'b00, 2'b00, 3'b000));
    trace_q.push_back(mk(S_IR,  2'b00, 2'b10, 3'b000));
    trace_q.push_back('0);
    is_branch = 1'b0;
    taken = 1'b0;
    case (op)
      8'h20: begin is_branch = 1'b1; taken = 1'b1; end
      8'h23: begin is_branch = 1'b1; taken = ccr[2]; end
`ifdef COND_BRANCH_EXT_EN
      8'h21: begin is_branch = 1'b1; taken = ccr[3]; end
      8'h22: begin is_branch = 1'b1; taken = !ccr[2]; end
      8'h25: begin is_branch = 1'b1; taken = ccr[0]; end
`endif
      default: ;
    endcase
    if (is_branch) begin
      if (taken) begin
        trace_q.push_back(opaddr);
        trace_q.push_back('0);
        trace_q.push_back(mk(S_PCL, 2'b00, 2'b10, 3'b000));
      end else begin
        trace_q.push_back(mk(S_PCI, 2'b00, 2'b00, 3'b000));
      end
    end else begin
      case (op)
        8'h86, 8'h88: begin
          trace_q.push_back(opaddr);
          trace_q.push_back(mk(S_PCI, 2'b00, 2'b00, 3'b000));
          trace_q.push_back(mk((op == 8'h86) ? S_A : S_B, 2'b00, 2'b10, 3'b000));
        end
        8'h87, 8'h89: begin
          trace_q.push_back(opaddr);
          trace_q.push_back(mk(S_PCI, 2'b00, 2'b00, 3'b000));
          trace_q.push_back(mk(S_MAR, 2'b00, 2'b10, 3'b000));
          trace_q.push_back('0);
          trace_q.push_back(mk((op == 8'h87) ? S_A : S_B, 2'b00, 2'b10, 3'b000));
        end
        8'h96, 8'h97: begin
          trace_q.push_back(opaddr);
          trace_q.push_back(mk(S_PCI, 2'b00, 2'b00, 3'b000));
          trace_q.push_back(mk(S_MAR, 2'b00, 2'b10, 3'b000));
          trace_q.push_back(mk(S_WR, (op == 8'h96) ? 2'b01 : 2'b10, 2'b00, 3'b000));
        end
        8'h42: trace_q.push_back(mk(S_A | S_CCR, 2'b10, 2'b00, 3'b000));
        8'h43: trace_q.push_back(mk(S_A | S_CCR, 2'b10, 2'b00, 3'b001));
        default: ;
      endcase
    end
  endtask

  // driver: one instruction; abort_at >= 0 pulses Reset in that cycle
  task automatic run_instr(input logic [7:0] op, input logic [3:0] ccr, input int abort_at);
    int n;
    build_trace(op, ccr);
    n = trace_q.size();
    for (int i = 0; i < n; i++) begin
      cu.IR = (i >= 3) ? op : 8'($urandom);
      cu.CCR_Result = (i == 3) ? ccr : 4'($urandom);
      if (i == abort_at) begin
        Reset = 1'b1;
        exp_q.push_back('0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        return;
      end
      exp_q.push_back(trace_q[i]);
      @(posedge Clk);
      #1;
    end
  endtask

  // monitor / scoreboard
  always @(negedge Clk) begin
    if (run) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL underflow: got=%h, expected queue empty", act);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (act !== e) begin
          fails++;
          $display("FAIL trace t=%0t: got=%h expected=%h", $time, act, e);
        end
      end
      tests++;
      if (cu.write && (cu.IR_Load || cu.MAR_Load || cu.PC_Load || cu.A_Load ||
                       cu.B_Load || cu.CCR_Load)) begin
        fails++;
        $display("FAIL write_excl t=%0t: got strobes=%h required no load with write", $time, act);
      end
      tests++;
      if (cu.PC_Load && cu.PC_Inc) begin
        fails++;
        $display("FAIL pc_excl t=%0t: got PC_Load=1 PC_Inc=1 required not both", $time);
      end
    end
  end

  initial begin
    logic [7:0] ops[14];
    logic [7:0] op;
    int abort_at;
    ops = '{8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97, 8'h42, 8'h43,
            8'h20, 8'h23, 8'h21, 8'h22, 8'h25, 8'h00};
    tests = 0;
    fails = 0;
    run = 1'b1;
    Reset = 1'b1;
    cu.IR = 8'h00;
    cu.CCR_Result = 4'h0;
    @(posedge Clk);
    #1;
    exp_q.push_back('0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    run_instr(8'h86, 4'h0, -1);
    run_instr(8'h96, 4'h0, -1);
    run_instr(8'h42, 4'hF, -1);
    run_instr(8'h23, 4'b0100, -1);
    run_instr(8'h23, 4'b0000, -1);
    run_instr(8'h21, 4'b1000, -1);
    run_instr(8'h22, 4'b0000, -1);
    run_instr(8'h25, 4'b0001, -1);
    run_instr(8'hFF, 4'h0, -1);
    run_instr(8'h87, 4'h0, 5);

    for (int k = 0; k < 300; k++) begin
      op = ops[$urandom_range(0, 13)];
      if (op == 8'h00) op = 8'($urandom);
      abort_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 8)) : -1;
      run_instr(op, 4'($urandom), abort_at);
    end

    @(negedge Clk);
    run = 1'b0;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Moore FSM that sequences the 8-bit accumulator datapath: instruction fetch, decode and execute.
- Drives every datapath load strobe, bus-mux select, ALU select and the memory write strobe.
- Consumes the instruction register and the registered NZVC flags.
- Sits between the datapath and the memory system inside the CPU top.

Parameters:
- Z_BIT, 2, bit index of Zero in CCR_Result (flag order: [3]=N, [2]=Z, [1]=V, [0]=C).
- ALU_ADD, 3'b000, ALU_Sel code for A+B.
- ALU_SUB, 3'b001, ALU_Sel code for A-B.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- IR  input  8  current opcode from the instruction register.
- CCR_Result  input  4  registered NZVC flags.
- IR_Load  output  1  load IR from Bus2.
- MAR_Load  output  1  load MAR from Bus2.
- PC_Load  output  1  load PC from Bus2.
- PC_Inc  output  1  PC <= PC+1 (8-bit wrap, 0xFF->0x00).
- A_Load  output  1  load A from Bus2.
- B_Load  output  1  load B from Bus2.
- ALU_Sel  output  3  ALU operation.
- CCR_Load  output  1  load CCR from ALU flags.
- Bus1_Sel  output  2  00=PC, 01=A, 10=B.
- Bus2_Sel  output  2  00=ALU_Result, 01=Bus1, 10=from_memory.
- write  output  1  memory write strobe; data is Bus1, address is MAR.

Behaviour:
- One clock (Clk); reset synchronous, active-high (Reset).
- Reset sampled high: next state S_FETCH_0. While Reset is high, all outputs are forced to idle: strobes 0, selects 00, ALU_Sel 000.
- Outputs depend on the current state only. A state's outputs take effect at the clock edge that leaves that state.
- Default in every state: strobes 0, Bus1_Sel=00, Bus2_Sel=00, ALU_Sel=000. Only the deviations are listed below.
- Fetch:
  - S_FETCH_0: Bus1_Sel=00, Bus2_Sel=01, MAR_Load.
  - S_FETCH_1: PC_Inc.
  - S_FETCH_2: Bus2_Sel=10, IR_Load.
  - S_DECODE_3: no strobes; branch on IR.
- Execute (opcode: state sequence). OPADDR means Bus2_Sel=01 + MAR_Load, followed by PC_Inc. Every sequence returns to S_FETCH_0.
  - LDA_IMM 0x86: OPADDR, PC_Inc; then Bus2_Sel=10 + A_Load. 3 states.
  - LDA_DIR 0x87: OPADDR, PC_Inc; Bus2_Sel=10 + MAR_Load; wait (memory read latency 1); Bus2_Sel=10 + A_Load. 5 states.
  - LDB_IMM 0x88 / LDB_DIR 0x89: same as LDA, with B_Load.
  - STA_DIR 0x96: OPADDR, PC_Inc; Bus2_Sel=10 + MAR_Load; Bus1_Sel=01 + write. 4 states.
  - STB_DIR 0x97: same as STA_DIR, with Bus1_Sel=10.
  - ADD_AB 0x42: Bus1_Sel=10, Bus2_Sel=00, ALU_Sel=ALU_ADD, A_Load, CCR_Load. 1 state.
  - SUB_AB 0x43: as ADD_AB, with ALU_Sel=ALU_SUB.
  - BRA 0x20: OPADDR; wait; Bus2_Sel=10 + PC_Load. 3 states.
  - BEQ 0x23:
    - CCR_Result[Z_BIT] is sampled in S_DECODE_3.
    - Z=1: BRA sequence.
    - Z=0: single state with PC_Inc (skip operand).
- Undefined opcode: S_DECODE_3 -> S_FETCH_0 (NOP, 4 cycles total). PC advances by 1.
- Reset mid-instruction aborts it. Partially loaded registers are not restored; the next fetch starts at the current datapath PC.
- Instruction lengths in cycles, fetch included:
  - LDx_IMM 7, LDx_DIR 9, STx_DIR 8, ADD/SUB 5.
  - BRA 7; BEQ 7 when taken, 5 when not taken.
- The FSM never asserts write together with any load strobe. The FSM never asserts PC_Load together with PC_Inc.

Optional Feature:
- COND_BRANCH_EXT_EN defined: adds three conditional branches, using the same taken/not-taken sequences as BEQ:
  - BMI 0x21: taken when N=1.
  - BNE 0x22: taken when Z=0.
  - BCS 0x25: taken when C=1.
- COND_BRANCH_EXT_EN undefined: 0x21, 0x22 and 0x25 decode as undefined opcodes (NOP path).

Test Plan:
- Reset high 2 cycles, then low -> all outputs idle during reset. First cycle after: MAR_Load=1, Bus1_Sel=00, Bus2_Sel=01.
- IR=0x86 after fetch -> strobe trace MAR_Load, PC_Inc, IR_Load, none, MAR_Load, PC_Inc, A_Load(Bus2_Sel=10), then MAR_Load again. 7-cycle period.
- IR=0x96 -> write=1 with Bus1_Sel=01 exactly one cycle, in the 8th cycle after fetch start. No other strobe in that cycle.
- IR=0x42 -> single execute cycle with A_Load=1, CCR_Load=1, ALU_Sel=000, Bus1_Sel=10, Bus2_Sel=00.
- IR=0x23 with CCR_Result=4'b0100 -> PC_Load in cycle 7. Same with CCR_Result=4'b0000 -> PC_Inc in cycle 5, no PC_Load.
- IR=0x21, CCR_Result=4'b1000 -> PC_Load when COND_BRANCH_EXT_EN is defined. Without the macro -> return to fetch after 4 cycles.
